// File: rtl/ieeedrv_trkbuf_ctl.sv
// Track-buffer sequencer for the IEEE drive: flushes a dirty track, computes the image
// sector offset of the requested track and reloads it over the SD block interface.
module ieeedrv_trkbuf_ctl #(
  parameter int unsigned SUBDRV = 2
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              drv_type,
  input  logic              drv_act,
  input  logic [7:0]        track,
  input  logic              buff_we,
  input  logic [SUBDRV-1:0] img_mounted,
  input  logic [31:0]       img_size,
  input  logic              img_readonly,
  output logic              loaded,
  output logic              wprot,
  output logic              busy,
  output logic [31:0]       sd_lba,
  output logic [5:0]        sd_blk_cnt,
  output logic [SUBDRV-1:0] sd_rd,
  output logic [SUBDRV-1:0] sd_wr,
  input  logic [SUBDRV-1:0] sd_ack
);

  typedef enum logic [2:0] {
    StIdle, StCalc, StLoad, StLoadWait, StReady, StFlush, StFlushWait
  } state_e;

  state_e            state_q, state_d;
  logic              tgt_drv_q, tgt_drv_d;
  logic [7:0]        tgt_trk_q, tgt_trk_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [31:0]       acc_q, acc_d;
  logic [31:0]       lba_q, lba_d;
  logic [5:0]        blk_q, blk_d;
  logic              dirty_q, dirty_d;
  logic              reload_q, reload_d;
  logic [SUBDRV-1:0] mounted_q, mounted_d;
  logic [SUBDRV-1:0] ro_q, ro_d;
  logic              wprot_q;

  logic change_in, mount_act, valid_in;

  // Zone tables; 8250 tracks 78..154 repeat the 1..77 pattern.
  function automatic logic [5:0] trk_secs(input logic is4040, input logic [7:0] t);
    logic [7:0] z;
    z = (t > 8'd77) ? t - 8'd77 : t;
    if (is4040) begin
      if (t <= 8'd17)      trk_secs = 6'd21;
      else if (t <= 8'd24) trk_secs = 6'd19;
      else if (t <= 8'd30) trk_secs = 6'd18;
      else                 trk_secs = 6'd17;
    end else begin
      if (z <= 8'd39)      trk_secs = 6'd29;
      else if (z <= 8'd53) trk_secs = 6'd27;
      else if (z <= 8'd64) trk_secs = 6'd25;
      else                 trk_secs = 6'd23;
    end
  endfunction

  function automatic logic [SUBDRV-1:0] drv_oh(input logic d);
    drv_oh    = '0;
    drv_oh[d] = 1'b1;
  endfunction

  assign change_in = (drv_act != tgt_drv_q) || (track != tgt_trk_q);
  assign mount_act = img_mounted[drv_act];
  assign valid_in  = mounted_q[drv_act] && (track != 8'd0) &&
                     (drv_type ? (track <= 8'd35) : (track <= 8'd154));

  always_comb begin
    state_d   = state_q;
    tgt_drv_d = tgt_drv_q;
    tgt_trk_d = tgt_trk_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    lba_d     = lba_q;
    blk_d     = blk_q;
    dirty_d   = dirty_q;
    reload_d  = reload_q;
    mounted_d = mounted_q;
    ro_d      = ro_q;

    for (int unsigned d = 0; d < SUBDRV; d++) begin
      if (img_mounted[d]) begin
        mounted_d[d] = (img_size != 32'd0);
        ro_d[d]      = img_readonly;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (valid_in && !mount_act) begin
          tgt_drv_d = drv_act;
          tgt_trk_d = track;
          cnt_d     = 8'd1;
          acc_d     = 32'd0;
          reload_d  = 1'b0;
          state_d   = StCalc;
        end
      end
      StCalc: begin
        if (mount_act || !valid_in) begin
          state_d = StIdle;
        end else if (change_in) begin
          tgt_drv_d = drv_act;
          tgt_trk_d = track;
          cnt_d     = 8'd1;
          acc_d     = 32'd0;
        end else if (cnt_q == tgt_trk_q) begin
          lba_d   = acc_q;
          blk_d   = trk_secs(drv_type, tgt_trk_q) - 6'd1;
          state_d = StLoad;
        end else begin
          acc_d = acc_q + 32'(trk_secs(drv_type, cnt_q));
          cnt_d = cnt_q + 8'd1;
        end
      end
      StLoad:     if (sd_ack[tgt_drv_q]) state_d = StLoadWait;
      StLoadWait: begin
        if (!sd_ack[tgt_drv_q]) begin
          dirty_d = 1'b0;
          state_d = StReady;
        end
      end
      StReady: begin
        if (change_in || reload_q || mount_act) begin
          // Write back keeps the current lba/blk latched for the flush.
          if (dirty_q && !ro_q[tgt_drv_q] && !mount_act && !img_mounted[tgt_drv_q]) begin
            state_d = StFlush;
          end else begin
            dirty_d = 1'b0;
            state_d = StIdle;
          end
        end else if (buff_we) begin
          dirty_d = 1'b1;
        end
      end
      StFlush:    if (sd_ack[tgt_drv_q]) state_d = StFlushWait;
      StFlushWait: begin
        if (!sd_ack[tgt_drv_q]) begin
          dirty_d = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (mount_act) begin
      dirty_d  = 1'b0;
      reload_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= StIdle;
      tgt_drv_q <= 1'b0;
      tgt_trk_q <= 8'd0;
      cnt_q     <= 8'd0;
      acc_q     <= 32'd0;
      lba_q     <= 32'd0;
      blk_q     <= 6'd0;
      dirty_q   <= 1'b0;
      reload_q  <= 1'b0;
      mounted_q <= '0;
      ro_q      <= '0;
      wprot_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_drv_q <= tgt_drv_d;
      tgt_trk_q <= tgt_trk_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      lba_q     <= lba_d;
      blk_q     <= blk_d;
      dirty_q   <= dirty_d;
      reload_q  <= reload_d;
      mounted_q <= mounted_d;
      ro_q      <= ro_d;
      wprot_q   <= ro_q[drv_act];
    end
  end

  // loaded is gated combinationally so it drops in the very cycle a change appears.
  assign loaded     = (state_q == StReady) && !change_in && !reload_q && !mount_act && !reset;
  assign busy       = (state_q != StIdle) && (state_q != StReady);
  assign wprot      = wprot_q;
  assign sd_lba     = lba_q;
  assign sd_blk_cnt = blk_q;
  assign sd_rd      = (state_q == StLoad)  ? drv_oh(tgt_drv_q) : '0;
  assign sd_wr      = (state_q == StFlush) ? drv_oh(tgt_drv_q) : '0;

endmodule

// File: tb/tb_ieeedrv_trkbuf_ctl.sv
// Scoreboard bench for ieeedrv_trkbuf_ctl: expected SD transfers are queued with the
// stimulus and compared when the controller raises sd_rd/sd_wr.
module tb_ieeedrv_trkbuf_ctl;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        drv_type;
  logic        drv_act;
  logic [7:0]  track;
  logic        buff_we;
  logic [1:0]  img_mounted;
  logic [31:0] img_size;
  logic        img_readonly;
  logic        loaded;
  logic        wprot;
  logic        busy;
  logic [31:0] sd_lba;
  logic [5:0]  sd_blk_cnt;
  logic [1:0]  sd_rd;
  logic [1:0]  sd_wr;
  logic [1:0]  sd_ack;

  typedef struct {
    logic        wr;
    logic [1:0]  mask;
    logic [31:0] lba;
    logic [5:0]  blk;
  } xfer_t;

  xfer_t exp_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  int    calc_n;

  ieeedrv_trkbuf_ctl #(.SUBDRV(2)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .drv_type     (drv_type),
    .drv_act      (drv_act),
    .track        (track),
    .buff_we      (buff_we),
    .img_mounted  (img_mounted),
    .img_size     (img_size),
    .img_readonly (img_readonly),
    .loaded       (loaded),
    .wprot        (wprot),
    .busy         (busy),
    .sd_lba       (sd_lba),
    .sd_blk_cnt   (sd_blk_cnt),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .sd_ack       (sd_ack)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic expect_xfer(input logic wr, input logic [1:0] mask, input int lba,
                             input int blk);
    xfer_t e;
    e.wr   = wr;
    e.mask = mask;
    e.lba  = 32'(lba);
    e.blk  = 6'(blk);
    exp_q.push_back(e);
  endtask

  task automatic mount(input logic d, input int size, input logic ro);
    @(negedge clk_sys);
    img_mounted    = 2'b00;
    img_mounted[d] = 1'b1;
    img_size       = 32'(size);
    img_readonly   = ro;
    @(negedge clk_sys);
    img_mounted = 2'b00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk_sys);
  endtask

  // Acts as the SD host for one transfer; new_trk >= 0 is applied while ack is held.
  task automatic service(input int new_trk, output int calc_cycles);
    xfer_t e;
    int    n;
    logic [1:0] m;
    calc_cycles = 0;
    n = 0;
    while (n < 2000) begin
      @(negedge clk_sys);
      if (sd_rd != 2'b00 || sd_wr != 2'b00) break;
      if (busy) calc_cycles++;
      n++;
    end
    if (n >= 2000) begin
      check("xfer_timeout", 32'd1, 32'd0);
      return;
    end
    if (exp_q.size() == 0) begin
      check("unexpected_xfer", 32'(sd_rd | sd_wr), 32'd0);
      return;
    end
    e = exp_q.pop_front();
    m = e.wr ? sd_wr : sd_rd;
    check("xfer_is_wr", 32'(sd_wr != 2'b00), 32'(e.wr));
    check("xfer_mask", 32'(m), 32'(e.mask));
    check("xfer_lba", sd_lba, e.lba);
    check("xfer_blk", 32'(sd_blk_cnt), 32'(e.blk));
    check("xfer_busy", 32'(busy), 32'd1);
    sd_ack = sd_rd | sd_wr;
    @(negedge clk_sys);
    check("req_drop", 32'(sd_rd | sd_wr), 32'd0);
    if (new_trk >= 0) track = 8'(new_trk);
    @(negedge clk_sys);
    @(negedge clk_sys);
    sd_ack = 2'b00;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!loaded && n < 200) begin
      @(negedge clk_sys);
      n++;
    end
    check(tag, 32'(loaded), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; drv_type = 1'b1; drv_act = 1'b0; track = 8'd18; buff_we = 1'b0;
    img_mounted = 2'b00; img_size = 32'd0; img_readonly = 1'b0; sd_ack = 2'b00;
    idle(3);
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wprot", 32'(wprot), 32'd0);
    check("rst_rdwr", 32'(sd_rd | sd_wr), 32'd0);
    check("rst_lba", sd_lba, 32'd0);
    reset = 1'b0;

    // Unmounted drive stays idle.
    idle(6);
    check("unmnt_busy", 32'(busy), 32'd0);
    check("unmnt_loaded", 32'(loaded), 32'd0);

    // 4040, track 18.
    expect_xfer(1'b0, 2'b01, 357, 18);
    mount(1'b0, 174848, 1'b0);
    service(-1, calc_n);
    wait_ready("t18_loaded");
    check("t18_wprot", 32'(wprot), 32'd0);

    // Out-of-range tracks on 4040.
    @(negedge clk_sys); track = 8'd0;
    #1 check("t0_drop", 32'(loaded), 32'd0);
    idle(6);
    check("t0_loaded", 32'(loaded), 32'd0);
    check("t0_busy", 32'(busy), 32'd0);
    track = 8'd36;
    idle(6);
    check("t36_loaded", 32'(loaded), 32'd0);
    check("t36_busy", 32'(busy), 32'd0);

    // 8250 zones.
    expect_xfer(1'b0, 2'b01, 0, 28);
    drv_type = 1'b0; track = 8'd1;
    service(-1, calc_n);
    wait_ready("d8_t1_loaded");
    expect_xfer(1'b0, 2'b01, 1131, 26);
    track = 8'd40;
    service(-1, calc_n);
    check("d8_t40_calc_cycles", 32'(calc_n), 32'd40);
    wait_ready("d8_t40_loaded");

    // Dirty flush then reload.
    expect_xfer(1'b0, 2'b01, 0, 20);
    drv_type = 1'b1; track = 8'd1;
    service(-1, calc_n);
    wait_ready("f_t1_loaded");
    buff_we = 1'b1;
    @(negedge clk_sys);
    buff_we = 1'b0;
    expect_xfer(1'b1, 2'b01, 0, 20);
    expect_xfer(1'b0, 2'b01, 21, 20);
    track = 8'd2;
    #1 check("f_drop", 32'(loaded), 32'd0);
    service(-1, calc_n);
    service(-1, calc_n);
    wait_ready("f_t2_loaded");

    // Read-only image: reload on mount, dirty never flushed.
    expect_xfer(1'b0, 2'b01, 21, 20);
    @(negedge clk_sys);
    img_mounted = 2'b01; img_size = 32'd174848; img_readonly = 1'b1;
    #1 check("ro_mount_drop", 32'(loaded), 32'd0);
    @(negedge clk_sys);
    img_mounted = 2'b00;
    service(-1, calc_n);
    wait_ready("ro_t2_loaded");
    check("ro_wprot", 32'(wprot), 32'd1);
    buff_we = 1'b1;
    @(negedge clk_sys);
    buff_we = 1'b0;
    expect_xfer(1'b0, 2'b01, 0, 20);
    track = 8'd1;
    service(-1, calc_n);
    wait_ready("ro_t1_loaded");

    // Track change during LOAD_WAIT.
    expect_xfer(1'b0, 2'b01, 0, 20);
    mount(1'b0, 174848, 1'b0);
    service(-1, calc_n);
    wait_ready("lw_t1_loaded");
    check("lw_wprot", 32'(wprot), 32'd0);
    expect_xfer(1'b0, 2'b01, 84, 20);
    expect_xfer(1'b0, 2'b01, 168, 20);
    track = 8'd5;
    service(9, calc_n);
    @(negedge clk_sys);
    check("lw_stale_loaded", 32'(loaded), 32'd0);
    service(-1, calc_n);
    wait_ready("lw_t9_loaded");

    // Reset while a read is pending.
    track = 8'd20;
    begin
      int n = 0;
      while (sd_rd == 2'b00 && n < 200) begin
        @(negedge clk_sys);
        n++;
      end
    end
    check("pre_rst_rd", 32'(sd_rd), 32'd1);
    reset = 1'b1;
    @(negedge clk_sys);
    check("mid_rst_rd", 32'(sd_rd), 32'd0);
    check("mid_rst_wr", 32'(sd_wr), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_lba", sd_lba, 32'd0);
    check("mid_rst_blk", 32'(sd_blk_cnt), 32'd0);
    check("mid_rst_loaded", 32'(loaded), 32'd0);
    reset = 1'b0;
    idle(6);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_loaded", 32'(loaded), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ieeedrv_trkbuf_ctl.md
Name: ieeedrv_trkbuf_ctl

Overview:
- Sequences the 8 KB track buffer that feeds the IEEE drive track generator.
- On every drive-select or head-track change it first writes the current track back to the disk image if the buffer is dirty. It then computes the image sector offset of the new track and reads that whole track into the buffer over the MiSTer SD block interface.
- It raises `loaded` to the track generator only while the buffer holds valid data for the selected drive and track.

Parameters:
- SUBDRV, 2, number of sub-drives (images); width of all per-drive vectors.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- drv_type  in  1  1 = 4040 (35 tracks), 0 = 8250 (154 tracks).
- drv_act  in  1  selected sub-drive.
- track  in  8  requested track, 1-based.
- buff_we  in  1  track-generator buffer write strobe; marks the buffer dirty.
- img_mounted  in  SUBDRV  per-drive mount strobe.
- img_size  in  32  image size in bytes, sampled on the mount strobe.
- img_readonly  in  1  sampled on the mount strobe.
- loaded  out  1  buffer valid for (drv_act, track).
- wprot  out  1  write protect of the selected drive.
- busy  out  1  controller is in any state other than IDLE/READY.
- sd_lba  out  32  first image sector of the transfer (256-byte units).
- sd_blk_cnt  out  6  sectors in the transfer, minus 1.
- sd_rd  out  SUBDRV  read request, one-hot per drive.
- sd_wr  out  SUBDRV  write request, one-hot per drive.
- sd_ack  in  SUBDRV  transfer acknowledge from the SD host.

Behaviour:
- Reset values: all outputs 0; `dirty` = 0; per-drive `mounted` = 0; state IDLE.
- Sectors per track:
  - 4040: 21 for tracks 1-17, 19 for 18-24, 18 for 25-30, 17 for 31-35.
  - 8250: 29 for 1-39, 27 for 40-53, 25 for 54-64, 23 for 65-77; the same zone pattern repeats for 78-116, 117-130, 131-141, 142-154.
- A track is valid when it is 1..35 (4040) or 1..154 (8250) and the selected drive is mounted.
- Mount strobe for drive d:
  - `mounted[d]` <= (img_size != 0); `ro[d]` <= img_readonly.
  - If d == drv_act, clear `dirty` without flushing and force a reload.
- `wprot` = `ro[drv_act]`, registered.
- `loaded` drops in the same cycle that any of these is seen: a drv_act/track change, a mount of the active drive, or reset.
- States:
  - IDLE: target = (drv_act, track). If the target is invalid, stay here with `loaded` = 0. Otherwise go to CALC.
  - CALC: accumulate the sectors-per-track of tracks 1..target-1 into `lba_acc`, one track per clk_sys cycle, so the state lasts (target-1)+1 cycles. Latch sd_lba = `lba_acc` and sd_blk_cnt = sectors(target)-1. Go to LOAD.
  - LOAD: assert `sd_rd[target_drv]` and hold it until `sd_ack` rises, then go to LOAD_WAIT.
  - LOAD_WAIT: when `sd_ack` falls, latch cur = target, `dirty` = 0, and go to READY.
  - READY: `loaded` = 1.
    - `buff_we` sets `dirty`.
    - On a change with `dirty` = 1 and `ro[cur_drv]` = 0, go to FLUSH with the latched cur sd_lba/sd_blk_cnt unchanged.
    - On any other change, go to IDLE.
  - FLUSH: assert `sd_wr[cur_drv]` and hold it until `sd_ack` rises. FLUSH_WAIT: when `sd_ack` falls, clear `dirty` and go to IDLE.
- Changes arriving mid-CALC restart CALC with the new target.
- Changes arriving in LOAD/LOAD_WAIT/FLUSH/FLUSH_WAIT never abort the SD transaction. The target is re-evaluated when the controller returns to IDLE or READY; at READY a stale target goes straight to IDLE with no flush, since the buffer is clean.
- `buff_we` outside READY is ignored.
- A read-only image is never flushed; `dirty` is discarded.
- Reset mid-transaction drops sd_rd/sd_wr immediately; no abort handshake is sent.
- `busy` = 1 in CALC/LOAD/LOAD_WAIT/FLUSH/FLUSH_WAIT.

Test Plan:
- 4040 mounted on drive 0, track 18 -> sd_lba = 357, sd_blk_cnt = 18, sd_rd = 01. After ack: loaded = 1, busy = 0.
- 8250 mounted, track 40 -> sd_lba = 1131, sd_blk_cnt = 26. Track 1 -> sd_lba = 0, sd_blk_cnt = 28. CALC lasts exactly 40 cycles for track 40.
- At READY on track 1 (4040), pulse buff_we, then change to track 2 -> loaded = 0 the same cycle; sd_wr = 01 with sd_lba = 0, sd_blk_cnt = 20; then sd_rd with sd_lba = 21.
- Same as above but mounted read-only -> no sd_wr, and wprot = 1.
- Track changes 5 -> 9 during LOAD_WAIT -> the track-5 read completes, then loaded stays 0 and a read is issued with sd_lba = 168 (8 x 21).
- Reset asserted while sd_rd is high -> the next cycle all outputs are 0. An unmounted drive, or track 0/36 on a 4040, leaves the controller in IDLE with loaded = 0.
